// File: rtl/alu_result_fifo.sv
// FIFO buffering ALU result words together with their flags {C,V,Z,S}.
// Define STICKY_FLAGS_EN to add accumulated carry/overflow flags with a clear input.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               alu_out,
    input  logic                     carry_out,
    input  logic                     overflow,
    input  logic                     zero,
    input  logic                     signo,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               dato_out,
    output logic [3:0]               flags_out,
    output logic [$clog2(DEPTH):0]   cuenta,
    output logic                     lleno,
    output logic                     vacio,
`ifdef STICKY_FLAGS_EN
    input  logic                     clr_sticky,
    output logic [1:0]               sticky,
`endif
    output logic                     descarte
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic          descarte_q, descarte_d;
    logic          wr_en, rd_en;
    logic [7:0]    head;
`ifdef STICKY_FLAGS_EN
    logic [1:0]    sticky_q, sticky_d;
`endif

    assign lleno     = (cnt_q == CW'(DEPTH));
    assign vacio     = (cnt_q == '0);
    assign in_ready  = ~lleno;
    assign out_valid = ~vacio;
    assign wr_en     = in_valid & in_ready;
    assign rd_en     = out_valid & out_ready;
    assign cuenta    = cnt_q;
    assign descarte  = descarte_q;

    // When empty the outputs show the last entry popped, or zero after reset.
    assign head      = vacio ? hold_q : mem_q[rd_ptr_q];
    assign dato_out  = head[7:4];
    assign flags_out = head[3:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        descarte_d = in_valid & lleno;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef STICKY_FLAGS_EN
    // A flag arriving with the clear still sets its bit.
    always_comb begin
        sticky_d = clr_sticky ? 2'b00 : sticky_q;
        if (wr_en) begin
            sticky_d = sticky_d | {carry_out, overflow};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            descarte_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            descarte_q <= descarte_d;
        end
    end

    // Storage is left uninitialised; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {alu_out, carry_out, overflow, zero, signo};
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo using a queue scoreboard and count model.
// Exercises the sticky flags when built with STICKY_FLAGS_EN.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_out;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic          signo;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    dato_out;
    logic [3:0]    flags_out;
    logic [CW-1:0] cuenta;
    logic          lleno;
    logic          vacio;
    logic          descarte;
    logic          clr_sticky;
`ifdef STICKY_FLAGS_EN
    logic [1:0]    sticky;
    logic [1:0]    sticky_exp;
`endif

    int         checks;
    int         failures;
    logic [7:0] sb_q[$];
    int         model_cnt;
    logic [7:0] last_pop;
    logic       desc_exp;

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_out    (alu_out),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero),
        .signo      (signo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dato_out   (dato_out),
        .flags_out  (flags_out),
        .cuenta     (cuenta),
        .lleno      (lleno),
        .vacio      (vacio),
`ifdef STICKY_FLAGS_EN
        .clr_sticky (clr_sticky),
        .sticky     (sticky),
`endif
        .descarte   (descarte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            $error("[TB] %s", tag);
        end
    endtask

    task automatic reset_model();
        sb_q.delete();
        model_cnt = 0;
        last_pop  = 8'h00;
        desc_exp  = 1'b0;
`ifdef STICKY_FLAGS_EN
        sticky_exp = 2'b00;
`endif
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_output(input string tag);
        logic [7:0] head_exp;
        head_exp = (model_cnt > 0) ? sb_q[0] : last_pop;
        check({tag, ".cuenta"},    8'(cuenta),    8'(model_cnt));
        check({tag, ".vacio"},     8'(vacio),     8'(model_cnt == 0));
        check({tag, ".lleno"},     8'(lleno),     8'(model_cnt == DEPTH));
        check({tag, ".in_ready"},  8'(in_ready),  8'(model_cnt != DEPTH));
        check({tag, ".out_valid"}, 8'(out_valid), 8'(model_cnt != 0));
        check({tag, ".descarte"},  8'(descarte),  8'(desc_exp));
        check({tag, ".head"},      {dato_out, flags_out}, head_exp);
`ifdef STICKY_FLAGS_EN
        check({tag, ".sticky"},    8'(sticky),    8'(sticky_exp));
`endif
    endtask

    // Drive one cycle of inputs, check the pre-edge outputs, then advance the model.
    task automatic apply_stimulus(input string tag, input logic iv, input logic [3:0] d,
                                  input logic [3:0] f, input logic ordy, input logic clr);
        logic accept;
        logic pop;
        logic full_before;
        in_valid   = iv;
        alu_out    = d;
        carry_out  = f[3];
        overflow   = f[2];
        zero       = f[1];
        signo      = f[0];
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        check_output(tag);
        full_before = (model_cnt == DEPTH);
        accept      = iv && !full_before;
        pop         = ordy && (model_cnt > 0);
        @(posedge clk);
        if (pop) last_pop = sb_q.pop_front();
        if (accept) sb_q.push_back({d, f});
        model_cnt = model_cnt + (accept ? 1 : 0) - (pop ? 1 : 0);
        desc_exp  = iv && full_before;
`ifdef STICKY_FLAGS_EN
        if (clr) sticky_exp = 2'b00;
        if (accept) sticky_exp = sticky_exp | {f[3], f[2]};
`endif
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        alu_out    = 4'h0;
        carry_out  = 1'b0;
        overflow   = 1'b0;
        zero       = 1'b0;
        signo      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        reset_model();
        #1;
        check_output("reset");
        @(negedge clk);
        rst = 1'b0;

        // First write after reset becomes visible one edge later.
        apply_stimulus("w9",    1'b1, 4'h9, 4'b1010, 1'b0, 1'b0);
        apply_stimulus("r9",    1'b0, 4'h0, 4'h0,    1'b1, 1'b0);
        apply_stimulus("hold9", 1'b0, 4'h0, 4'h0,    1'b0, 1'b0);

        // Fill to full, overflow attempts, then drain in order.
        apply_stimulus("fill3", 1'b1, 4'h3, 4'b0001, 1'b0, 1'b0);
        apply_stimulus("fill5", 1'b1, 4'h5, 4'b0110, 1'b0, 1'b0);
        apply_stimulus("fill7", 1'b1, 4'h7, 4'b1100, 1'b0, 1'b0);
        apply_stimulus("fill9", 1'b1, 4'h9, 4'b0011, 1'b0, 1'b0);
        apply_stimulus("ovfF",  1'b1, 4'hF, 4'b1111, 1'b0, 1'b0);
        apply_stimulus("ovfRd", 1'b1, 4'hE, 4'b1110, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("drain%0d", i), 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        end
        apply_stimulus("rdEmpty0", 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        apply_stimulus("rdEmpty1", 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Steady simultaneous read/write at count 2 wraps the pointers.
        apply_stimulus("preA", 1'b1, 4'hA, 4'b0101, 1'b0, 1'b0);
        apply_stimulus("preB", 1'b1, 4'hB, 4'b1001, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus($sformatf("rw%0d", i), 1'b1, 4'(i), 4'(i * 5), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus($sformatf("rwDrain%0d", i), 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        end

        // Asynchronous reset with three entries stored.
        apply_stimulus("pre1", 1'b1, 4'h1, 4'b1000, 1'b0, 1'b0);
        apply_stimulus("pre2", 1'b1, 4'h2, 4'b0100, 1'b0, 1'b0);
        apply_stimulus("pre3", 1'b1, 4'h3, 4'b0010, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        reset_model();
        check_output("asyncRst");
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus("postRstW", 1'b1, 4'hC, 4'b0111, 1'b0, 1'b0);
        apply_stimulus("postRstR", 1'b0, 4'h0, 4'h0,    1'b1, 1'b0);

        // Sticky flags: carry set, then clear while an overflow write lands.
        apply_stimulus("stkC",   1'b1, 4'h4, 4'b1000, 1'b0, 1'b0);
        apply_stimulus("stkClr", 1'b1, 4'h6, 4'b0100, 1'b0, 1'b1);
        apply_stimulus("stkChk", 1'b0, 4'h0, 4'h0,    1'b1, 1'b0);
        apply_stimulus("stkEnd", 1'b0, 4'h0, 4'h0,    1'b1, 1'b0);
        apply_stimulus("final",  1'b0, 4'h0, 4'h0,    1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
